// File: rtl/me_mc_recon.sv
// Motion-compensated reconstruction of one 16x16 macroblock: it reads the reference block at the
// clamped MV origin, adds a streamed signed residual with saturation, and writes the destination block.
module me_mc_recon #(
    parameter int WIDTH  = 352,
    parameter int HEIGHT = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] ref_base_addr,
    input  logic [31:0] dst_base_addr,
    input  logic [31:0] mb_x_pos,
    input  logic [31:0] mb_y_pos,
    input  logic [5:0]  mv_x,
    input  logic [5:0]  mv_y,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic [8:0]  res_data,
    input  logic        res_valid,
    output logic        res_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [7:0]  pix_cnt_q;
    logic [31:0] ref_base_q, dst_base_q, mb_x_q, mb_y_q;
    logic [5:0]  mv_x_q, mv_y_q;
    logic        wr_en_q;
    logic [31:0] wr_addr_q;
    logic [7:0]  wr_data_q;

    logic signed [31:0] sx, sy, rx, ry;
    logic [31:0] row_off, col_off, ref_org, dst_org;
    logic signed [9:0] sum;
    logic [7:0]  pix_sat;
    logic        hs;

    assign sx = $signed(mb_x_q) + $signed({{26{mv_x_q[5]}}, mv_x_q});
    assign sy = $signed(mb_y_q) + $signed({{26{mv_y_q[5]}}, mv_y_q});

    // Clamping keeps the whole 16x16 reference window inside the frame.
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        rx = sx;
        ry = sy;
        if (sx < 0)                rx = '0;
        else if (sx > WIDTH - 16)  rx = 32'(WIDTH - 16);
        if (sy < 0)                ry = '0;
        else if (sy > HEIGHT - 16) ry = 32'(HEIGHT - 16);
    end

    assign row_off = 32'(pix_cnt_q[7:4]) * 32'(WIDTH);
    assign col_off = {28'd0, pix_cnt_q[3:0]};
    assign ref_org = ref_base_q + 32'(ry * WIDTH) + 32'(rx);
    assign dst_org = dst_base_q + mb_y_q * 32'(WIDTH) + mb_x_q;

    assign mem_addr  = (state_q == S_RUN) ? ref_org + row_off + col_off : '0;
    assign res_ready = (state_q == S_RUN);
    assign hs        = res_ready && res_valid;

    // Range is -256..510, so bit 9 flags negative and bit 8 flags overflow past 255.
    assign sum     = $signed({2'b00, mem_rdata}) + $signed({res_data[8], res_data});
    assign pix_sat = sum[9] ? 8'd0 : (sum[8] ? 8'd255 : sum[7:0]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (hs && pix_cnt_q == 8'd255) state_d = S_FLUSH;
            S_FLUSH: state_d = S_DONE;
            S_DONE:  if (!start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pix_cnt_q  <= '0;
            ref_base_q <= '0;
            dst_base_q <= '0;
            mb_x_q     <= '0;
            mb_y_q     <= '0;
            mv_x_q     <= '0;
            mv_y_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_en_q <= hs;
            if (state_q == S_IDLE && start) begin
                ref_base_q <= ref_base_addr;
                dst_base_q <= dst_base_addr;
                mb_x_q     <= mb_x_pos;
                mb_y_q     <= mb_y_pos;
                mv_x_q     <= mv_x;
                mv_y_q     <= mv_y;
                pix_cnt_q  <= '0;
            end
            if (hs) begin
                wr_addr_q <= dst_org + row_off + col_off;
                wr_data_q <= pix_sat;
                pix_cnt_q <= pix_cnt_q + 8'd1;
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_me_mc_recon.sv
// Table-driven bench for me_mc_recon: block vectors with hand-computed origins plus reset and start-hold sequences.
module tb_me_mc_recon;

    localparam int          W        = 352;
    localparam logic [31:0] REF_BASE = 32'h0001_0000;
    localparam logic [31:0] DST_BASE = 32'h0008_0000;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [31:0] ref_base_addr, dst_base_addr, mb_x_pos, mb_y_pos;
    logic [5:0]  mv_x, mv_y;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [8:0]  res_data;
    logic        res_valid, res_ready, wr_en, busy, done;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;

    me_mc_recon dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ref_base_addr(ref_base_addr), .dst_base_addr(dst_base_addr),
        .mb_x_pos(mb_x_pos), .mb_y_pos(mb_y_pos), .mv_x(mv_x), .mv_y(mv_y),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mb_x; int mb_y; int mv_x; int mv_y;
        int rx;   int ry;            // expected clamped read origin
        int ref_mode; int res_mode; int duty;
    } vec_t;

    vec_t vecs[5];
    int   n_pass = 0, n_chk = 0;
    int   ref_mode = 0, res_mode = 0, res_idx = 0;
    logic [31:0] got_addr[256];
    logic [7:0]  got_data[256];

    function automatic logic [7:0] ref_byte(input int mode, input logic [31:0] a);
        logic [31:0] off;
        off = a - REF_BASE;
        case (mode)
            0:       return a[7:0];
            1:       return 8'd200;
            default: return 8'((off / W) * 16 + (off % W));
        endcase
    endfunction

    function automatic int resid(input int mode, input int k);
        if (mode == 0) return 0;
        return (k % 2 == 0) ? 100 : -250;
    endfunction

    always_comb mem_rdata = ref_byte(ref_mode, mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic logic pick_valid(input int duty);
        return (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
    endfunction

    task automatic run_block(input vec_t v, input int hold, input string tag);
        int cyc, wcount, bad_wr, addr_err, data_err, done_at, hold_err, s;
        logic hs_prev, rd_seen, done_seen;
        logic [31:0] first_rd, org, ra, ea;
        logic [7:0]  ed;
        wcount = 0; bad_wr = 0; addr_err = 0; data_err = 0; done_at = -1; hold_err = 0;
        hs_prev = 1'b0; rd_seen = 1'b0; done_seen = 1'b0; first_rd = '0;
        @(posedge clk); #1;
        ref_mode = v.ref_mode; res_mode = v.res_mode; res_idx = 0;
        ref_base_addr = REF_BASE; dst_base_addr = DST_BASE;
        mb_x_pos = 32'(v.mb_x); mb_y_pos = 32'(v.mb_y);
        mv_x = 6'(v.mv_x); mv_y = 6'(v.mv_y);
        start = 1'b1;
        res_valid = pick_valid(v.duty);
        res_data = 9'(resid(res_mode, 0));
        for (cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
            @(negedge clk);
            if (wr_en !== hs_prev) bad_wr++;
            if (wr_en === 1'b1) begin
                if (wcount < 256) begin
                    got_addr[wcount] = wr_addr;
                    got_data[wcount] = wr_data;
                end
                wcount++;
            end
            if (!rd_seen && res_ready === 1'b1) begin
                first_rd = mem_addr;
                rd_seen = 1'b1;
            end
            hs_prev = res_valid && res_ready;
            if (hs_prev) res_idx++;
            if (done === 1'b1) begin
                done_seen = 1'b1;
                done_at = cyc;
            end else begin
                @(posedge clk); #1;
                mb_x_pos = '0; mb_y_pos = '0; mv_x = '0; mv_y = '0;
                res_valid = pick_valid(v.duty);
                res_data = 9'(resid(res_mode, res_idx));
            end
        end
        check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        org = REF_BASE + 32'(v.ry * W + v.rx);
        check({tag, "_read_origin"}, first_rd, org);
        check({tag, "_write_count"}, 32'(wcount), 32'd256);
        check({tag, "_wr_without_hs"}, 32'(bad_wr), 32'd0);
        for (int k = 0; k < 256 && k < wcount; k++) begin
            ra = org + 32'((k / 16) * W + (k % 16));
            ea = DST_BASE + 32'(v.mb_y * W + v.mb_x + (k / 16) * W + (k % 16));
            s = int'(ref_byte(v.ref_mode, ra)) + resid(v.res_mode, k);
            ed = (s < 0) ? 8'd0 : (s > 255) ? 8'd255 : 8'(s);
            if (got_addr[k] !== ea) addr_err++;
            if (got_data[k] !== ed) data_err++;
        end
        check({tag, "_addr_errors"}, 32'(addr_err), 32'd0);
        check({tag, "_data_errors"}, 32'(data_err), 32'd0);
        if (v.duty >= 100) check({tag, "_done_latency"}, 32'(done_at), 32'd258);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0 || res_ready !== 1'b0) hold_err++;
        end
        if (hold > 0) check({tag, "_hold_no_retrigger"}, 32'(hold_err), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_cleared"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{mb_x: 32,  mb_y: 32,  mv_x: 0,   mv_y: 0,   rx: 32,  ry: 32,  ref_mode: 0, res_mode: 0, duty: 100};
        vecs[1] = '{mb_x: 16,  mb_y: 16,  mv_x: -3,  mv_y: 5,   rx: 13,  ry: 21,  ref_mode: 1, res_mode: 1, duty: 100};
        vecs[2] = '{mb_x: 0,   mb_y: 0,   mv_x: -16, mv_y: -16, rx: 0,   ry: 0,   ref_mode: 2, res_mode: 0, duty: 100};
        vecs[3] = '{mb_x: 336, mb_y: 224, mv_x: 15,  mv_y: 15,  rx: 336, ry: 224, ref_mode: 2, res_mode: 1, duty: 100};
        vecs[4] = '{mb_x: 32,  mb_y: 32,  mv_x: 0,   mv_y: 0,   rx: 32,  ry: 32,  ref_mode: 0, res_mode: 0, duty: 30};

        rst_n = 1'b0; start = 1'b0; res_valid = 1'b0; res_data = '0;
        ref_base_addr = '0; dst_base_addr = '0; mb_x_pos = '0; mb_y_pos = '0; mv_x = '0; mv_y = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {mem_addr | wr_addr, 24'(wr_data), 8'({res_ready, wr_en, busy, done})}, 64'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_wr_addr", wr_addr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_block(vecs[i], 0, $sformatf("vec%0d", i));
            if (i == 0) check("vec0_first_wr_addr", got_addr[0], DST_BASE + 32'(32 * W + 32));
            if (i == 1) check("vec1_even_odd_sat", {24'd0, got_data[0], got_data[1]}, {24'd0, 8'd255, 8'd0});
        end

        // Reset while the block is in flight at pix_cnt=100.
        @(posedge clk); #1;
        ref_mode = 0; res_mode = 0; res_idx = 0;
        ref_base_addr = REF_BASE; dst_base_addr = DST_BASE;
        mb_x_pos = 32'd32; mb_y_pos = 32'd32; mv_x = '0; mv_y = '0;
        start = 1'b1; res_valid = 1'b1; res_data = '0;
        n = 0;
        while (res_idx < 100 && n < 500) begin
            @(negedge clk);
            if (res_valid && res_ready) res_idx++;
            n++;
        end
        check("abort_reached_pix100", 32'(res_idx), 32'd100);
        @(posedge clk); #1;
        rst_n = 1'b0; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_outputs", {28'd0, wr_en, busy, done, res_ready}, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; res_valid = 1'b0;
        @(negedge clk);
        check("abort_no_late_write", {31'd0, wr_en}, 32'd0);
        run_block(vecs[0], 0, "post_reset");

        // Start held high through DONE must not retrigger; a fresh start runs a new block.
        run_block(vecs[1], 10, "hold");
        run_block(vecs[2], 0, "restart");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/me_mc_recon.md
Name: me_mc_recon

Overview:
- Motion-compensated reconstruction engine. It is the consumer of the hexagon-search motion estimator's result.
- Given a macroblock position and a motion vector (mv_x, mv_y), it reads the 16x16 reference block from the reference frame over the shared byte-read memory interface.
- It adds a streamed signed residual to each pixel, saturates the sum, and writes the reconstructed 16x16 block into the destination frame.
- It sits after ME in the encoder reconstruction loop and serves as the decoder's MC stage.

Parameters:
WIDTH, 352, frame width in pixels (row stride)
HEIGHT, 240, frame height in pixels

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin one macroblock; level held by the master until done
ref_base_addr  in  32  byte address of reference frame pixel (0,0)
dst_base_addr  in  32  byte address of destination frame pixel (0,0)
mb_x_pos  in  32  macroblock top-left x (pixels)
mb_y_pos  in  32  macroblock top-left y (pixels)
mv_x  in  6  signed motion vector x, range -16..15
mv_y  in  6  signed motion vector y, range -16..15
mem_addr  out  32  reference read address
mem_rdata  in  8  reference byte, valid combinationally in the same cycle as mem_addr
res_data  in  9  signed residual, -256..255, raster order
res_valid  in  1  residual valid
res_ready  out  1  residual accepted when res_valid && res_ready
wr_en  out  1  destination write strobe
wr_addr  out  32  destination byte address
wr_data  out  8  reconstructed pixel
busy  out  1  high from the cycle after start is accepted until done rises
done  out  1  block complete

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset values: on any clock edge with rst_n=0, state=IDLE, pix_cnt=0. All outputs are 0: mem_addr, res_ready, wr_en, wr_addr, wr_data, busy, done.
- Reset mid-block: the block aborts immediately. No further wr_en is issued after the reset edge.
- States are IDLE, RUN, FLUSH, DONE.
- IDLE:
  - done=0.
  - On start=1, latch ref_base_addr, dst_base_addr, mb_x_pos, mb_y_pos, mv_x, mv_y into internal registers. Inputs may change afterwards.
  - Set pix_cnt=0, busy=1, go to RUN.
- Reference origin (computed from latched values):
  - rx = mb_x + sign-extended mv_x, clamped to [0, WIDTH-16].
  - ry = mb_y + sign-extended mv_y, clamped to [0, HEIGHT-16].
  - Arithmetic is 32-bit signed.
- RUN:
  - res_ready=1.
  - mem_addr = ref_base + (ry*WIDTH + rx) + pix_cnt[7:4]*WIDTH + pix_cnt[3:0]. mem_addr is combinational from state and pix_cnt, and is 0 outside RUN.
  - On a handshake (res_valid && res_ready):
    - sum = zero-extended mem_rdata + sign-extended res_data, computed at 10 bits signed.
    - wr_data <= 0 if sum<0, 255 if sum>255, otherwise sum[7:0].
    - wr_addr <= dst_base + mb_y*WIDTH + mb_x + pix_cnt[7:4]*WIDTH + pix_cnt[3:0].
    - wr_en <= 1, pix_cnt <= pix_cnt+1.
  - Without a handshake: wr_en <= 0 and pix_cnt holds (stall, no gap penalty).
  - The handshake at pix_cnt=255 goes to FLUSH.
- Write latency is exactly 1 cycle after the accepting edge: wr_en is high in the cycle following each handshake. Exactly 256 writes are issued per block.
- FLUSH: res_ready=0, wr_en <= 0. Go to DONE (the last write has been visible for one cycle).
- DONE:
  - busy=0, done=1.
  - Hold done until start=0, then go to IDLE, where done=0.
  - start held high in DONE does not retrigger.
- Residuals presented outside RUN are not accepted (res_ready=0).
- mv outside -16..15 cannot occur (6-bit signed); the clamp also covers the frame edges.
- Destination addressing is not clamped: mb_x <= WIDTH-16 and mb_y <= HEIGHT-16 is a master obligation.

Test Plan:
- mb (32,32), mv (0,0), residual all 0, res_valid constantly 1, ref pixel = (addr & 0xFF) -> 256 writes on consecutive cycles. wr_data equals the ref byte at the same offset, first wr_addr = dst_base+32*352+32, done 258 cycles after start.
- mb (16,16), mv (-3,5), ref all 200, residual +100 for even pixels and -250 for odd -> even pixels write 255 and odd pixels write 0. Read origin is (13,21).
- mb (0,0), mv (-16,-16), ref byte = row*16+col -> reads start at ref_base+0 (clamped). Likewise mb (336,224), mv (15,15) clamps to (336,224).
- res_valid toggled randomly at 30% duty -> still exactly 256 writes, in raster order. No wr_en in any cycle not preceded by a handshake, and results match the all-valid run.
- rst_n=0 asserted at pix_cnt=100 -> on the next edge wr_en=0, busy=0, done=0, res_ready=0. A fresh start then completes a full 256-write block.
- start held high through DONE for 10 cycles -> done stays 1 with no second block. Start low -> done=0 next cycle. A pulse of start then starts a new block.
